// File: rtl/dso_host_pkg.sv
// Shared types and constants for the DSO host-side command engine.
// Opcodes match the DSO_dig command decoder.
package dso_host_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        TRMT,
        WAIT_TX,
        WAIT_RX,
        FWD,
        CLR,
        DONE
    } host_state_t;

    localparam logic [7:0] ACK_BYTE_DEF = 8'hA5;

    localparam logic [7:0] DUMP_CH  = 8'h01;
    localparam logic [7:0] CFG_GAIN = 8'h02;
    localparam logic [7:0] TRIG_LVL = 8'h03;
    localparam logic [7:0] TRIG_POS = 8'h04;
    localparam logic [7:0] SET_DEC  = 8'h05;
    localparam logic [7:0] TRIG_CFG = 8'h06;
    localparam logic [7:0] TRIG_RD  = 8'h07;
    localparam logic [7:0] EEP_WR   = 8'h08;
    localparam logic [7:0] EEP_RD   = 8'h09;

endpackage

// File: rtl/host_wait_timer.sv
// Idle-cycle counter for the host engine; expires when it saturates at all-ones.
module host_wait_timer #(
    parameter int unsigned TO_W = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired
);

    logic [TO_W-1:0] cnt;

    assign expired = (cnt == '1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= '0;
        else if (en && !expired)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/uart_cmd_host.sv
// Host command engine: sends an N-byte command MSB-first over trmt/tx_done,
// then collects and forwards a programmable number of response bytes.
module uart_cmd_host
    import dso_host_pkg::*;
#(
    parameter int unsigned CMD_BYTES = 3,
    parameter int unsigned RESP_W    = 16,
    parameter int unsigned TO_W      = 20,
    parameter logic [7:0]  ACK_BYTE  = ACK_BYTE_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [8*CMD_BYTES-1:0] cmd,
    input  logic [RESP_W-1:0]      resp_cnt,
    input  logic                   send_cmd,
    input  logic                   abort,
    output logic                   busy,
    output logic [7:0]             tx_data,
    output logic                   trmt,
    input  logic                   tx_done,
    input  logic [7:0]             rx_data,
    input  logic                   rx_rdy,
    output logic                   clr_rx_rdy,
    output logic [7:0]             resp_data,
    output logic                   resp_vld,
    input  logic                   resp_ack,
    output logic                   done,
    output logic                   ack_ok,
    output logic                   timeout
);

    localparam int unsigned        CMD_W    = 8 * CMD_BYTES;
    localparam int unsigned        IDX_W    = $clog2(CMD_BYTES + 1);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(CMD_BYTES - 1);

    host_state_t       state, state_nxt;
    logic [CMD_W-1:0]  shreg;
    logic [CMD_W-1:0]  shreg_nxt;
    logic [RESP_W-1:0] rem_cnt;
    logic [IDX_W-1:0]  byte_idx;
    logic              first_rx;
    logic              tx_done_q;
    logic              tx_rise;
    logic              accept;
    logic              tx_adv;
    logic              rx_take;
    logic              tmo_hit;
    logic              tmr_load;
    logic              tmr_en;
    logic              tmr_expired;

    assign tx_rise   = tx_done & ~tx_done_q;
    assign shreg_nxt = shreg << 8;

    host_wait_timer #(.TO_W(TO_W)) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        trmt       = 1'b0;
        clr_rx_rdy = 1'b0;
        resp_vld   = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        tx_adv     = 1'b0;
        rx_take    = 1'b0;
        tmo_hit    = 1'b0;
        unique case (state)
            IDLE: begin
                if (send_cmd && !abort) begin
                    accept    = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                busy      = 1'b1;
                state_nxt = TRMT;
            end
            TRMT: begin
                busy      = 1'b1;
                trmt      = 1'b1;
                state_nxt = WAIT_TX;
            end
            WAIT_TX: begin
                busy = 1'b1;
                if (tx_rise) begin
                    tx_adv = 1'b1;
                    if (byte_idx == LAST_IDX)
                        state_nxt = (rem_cnt == '0) ? DONE : WAIT_RX;
                    else
                        state_nxt = LOAD;
                end else if (tmr_expired) begin
                    tmo_hit   = 1'b1;
                    state_nxt = DONE;
                end
            end
            WAIT_RX: begin
                busy = 1'b1;
                if (rx_rdy) begin
                    rx_take   = 1'b1;
                    state_nxt = FWD;
                end else if (tmr_expired) begin
                    tmo_hit   = 1'b1;
                    state_nxt = DONE;
                end
            end
            FWD: begin
                busy     = 1'b1;
                resp_vld = 1'b1;
                if (resp_ack)
                    state_nxt = CLR;
            end
            CLR: begin
                busy       = 1'b1;
                clr_rx_rdy = 1'b1;
                state_nxt  = (rem_cnt == RESP_W'(1)) ? DONE : WAIT_RX;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Abort overrides every in-flight transition, including datapath updates.
        if (abort && state != IDLE && state != DONE) begin
            state_nxt = DONE;
            tx_adv    = 1'b0;
            rx_take   = 1'b0;
            tmo_hit   = 1'b0;
        end
        // Counter restarts on every entry into a wait state, including wait-to-wait.
        tmr_load = !((state == WAIT_TX || state == WAIT_RX) && state_nxt == state);
        tmr_en   = !tmr_load;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg     <= '0;
            tx_data   <= '0;
            rem_cnt   <= '0;
            byte_idx  <= '0;
            first_rx  <= 1'b0;
            tx_done_q <= 1'b0;
            resp_data <= '0;
            ack_ok    <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            tx_done_q <= tx_done;
            if (accept) begin
                shreg    <= cmd;
                tx_data  <= cmd[CMD_W-1 -: 8];
                rem_cnt  <= resp_cnt;
                byte_idx <= '0;
                first_rx <= 1'b1;
                ack_ok   <= 1'b0;
                timeout  <= 1'b0;
            end
            if (tx_adv) begin
                shreg    <= shreg_nxt;
                tx_data  <= shreg_nxt[CMD_W-1 -: 8];
                byte_idx <= byte_idx + 1'b1;
            end
            if (rx_take) begin
                resp_data <= rx_data;
                if (first_rx) begin
                    ack_ok   <= (rx_data == ACK_BYTE);
                    first_rx <= 1'b0;
                end
            end
            if (state == CLR && rem_cnt != '0)
                rem_cnt <= rem_cnt - 1'b1;
            if (tmo_hit)
                timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_cmd_host.sv
// Directed bench for uart_cmd_host with simple UART tx/rx and downstream models.
module tb_uart_cmd_host;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;

    logic [23:0] cmd_a = '0;
    logic [15:0] resp_cnt_a = '0;
    logic        send_a = 1'b0;
    logic        abort_a = 1'b0;
    logic        busy_a, trmt_a, clr_a, resp_vld_a, done_a, ack_ok_a, timeout_a;
    logic [7:0]  tx_data_a, resp_data_a;
    logic        tx_done_a = 1'b0;
    logic [7:0]  rx_data_a = '0;
    logic        rx_rdy_a = 1'b0;
    logic        resp_ack_a = 1'b0;

    logic [31:0] cmd_b = '0;
    logic        send_b = 1'b0;
    logic        busy_b, trmt_b, clr_b, resp_vld_b, done_b, ack_ok_b, timeout_b;
    logic [7:0]  tx_data_b, resp_data_b;
    logic        tx_done_b = 1'b0;

    int          total = 0;
    int          bad = 0;

    logic [7:0]  tx_log_a[$];
    logic [7:0]  tx_log_b[$];
    logic [7:0]  rx_q[$];
    logic [7:0]  got_q[$];
    int          n_trmt_a = 0, n_clr_a = 0, n_done_a = 0, n_unstable = 0, n_txjit = 0;
    int          n_trmt_b = 0, n_clr_b = 0, n_vld_b = 0, n_done_b = 0;
    int          txw_a = 0, txw_b = 0, txd_cyc = 0, done_cyc = 0;
    int          ack_mode = 0;
    logic        stall_prev = 1'b0;
    logic [7:0]  stall_data = '0;
    logic [7:0]  txd_prev_a = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_cmd_host #(.CMD_BYTES(3), .RESP_W(16), .TO_W(6), .ACK_BYTE(8'hA5)) u_dut_a (
        .clk(clk), .rst(rst), .cmd(cmd_a), .resp_cnt(resp_cnt_a), .send_cmd(send_a),
        .abort(abort_a), .busy(busy_a), .tx_data(tx_data_a), .trmt(trmt_a),
        .tx_done(tx_done_a), .rx_data(rx_data_a), .rx_rdy(rx_rdy_a), .clr_rx_rdy(clr_a),
        .resp_data(resp_data_a), .resp_vld(resp_vld_a), .resp_ack(resp_ack_a),
        .done(done_a), .ack_ok(ack_ok_a), .timeout(timeout_a)
    );

    uart_cmd_host #(.CMD_BYTES(4), .RESP_W(16), .TO_W(6), .ACK_BYTE(8'hA5)) u_dut_b (
        .clk(clk), .rst(rst), .cmd(cmd_b), .resp_cnt(16'd0), .send_cmd(send_b),
        .abort(1'b0), .busy(busy_b), .tx_data(tx_data_b), .trmt(trmt_b),
        .tx_done(tx_done_b), .rx_data(8'h00), .rx_rdy(1'b0), .clr_rx_rdy(clr_b),
        .resp_data(resp_data_b), .resp_vld(resp_vld_b), .resp_ack(1'b1),
        .done(done_b), .ack_ok(ack_ok_b), .timeout(timeout_b)
    );

    // Models: UART tx completes 4 cycles after trmt, rx presents queued bytes
    // until cleared, downstream acks per ack_mode (0 always, 1 random, 2 never).
    always @(negedge clk) begin
        logic ack;
        if (trmt_a) begin
            tx_log_a.push_back(tx_data_a);
            n_trmt_a++;
            if (tx_data_a !== txd_prev_a) n_txjit++;
            tx_done_a = 1'b0;
            txw_a = 4;
        end else if (txw_a != 0) begin
            txw_a--;
            if (txw_a == 0) begin
                tx_done_a = 1'b1;
                txd_cyc = cyc;
            end
        end
        txd_prev_a = tx_data_a;

        if (trmt_b) begin
            tx_log_b.push_back(tx_data_b);
            n_trmt_b++;
            tx_done_b = 1'b0;
            txw_b = 4;
        end else if (txw_b != 0) begin
            txw_b--;
            if (txw_b == 0) tx_done_b = 1'b1;
        end
        if (clr_b) n_clr_b++;
        if (resp_vld_b) n_vld_b++;
        if (done_b) n_done_b++;

        if (rst) begin
            rx_rdy_a = 1'b0;
            rx_q.delete();
        end else if (clr_a) begin
            rx_rdy_a = 1'b0;
            n_clr_a++;
        end else if (!rx_rdy_a && rx_q.size() != 0) begin
            rx_data_a = rx_q.pop_front();
            rx_rdy_a = 1'b1;
        end

        if (stall_prev && (!resp_vld_a || resp_data_a !== stall_data)) n_unstable++;
        if (ack_mode == 0) ack = 1'b1;
        else if (ack_mode == 1) ack = 1'($urandom_range(0, 1));
        else ack = 1'b0;
        resp_ack_a = ack;
        if (resp_vld_a && ack) got_q.push_back(resp_data_a);
        stall_prev = resp_vld_a && !ack;
        stall_data = resp_data_a;
        if (done_a) n_done_a++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_a(input logic [23:0] c, input logic [15:0] n);
        cmd_a = c;
        resp_cnt_a = n;
        send_a = 1'b1;
        @(negedge clk);
        send_a = 1'b0;
    endtask

    task automatic wait_done_a(input string tag);
        int unsigned n = 0;
        while (done_a !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check({tag, " done seen"}, done_a, 1);
        done_cyc = cyc;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int s_trmt, s_clr, s_done, s_uns, errs;
        int unsigned n;
        logic [7:0] e;

        repeat (3) @(negedge clk);
        check("reset busy", busy_a, 0);
        check("reset strobes", {trmt_a, clr_a, resp_vld_a, done_a, ack_ok_a, timeout_a}, 0);
        check("reset tx_data", tx_data_a, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle after reset", {busy_a, trmt_a, clr_a}, 0);

        // EEP write with an ignored send_cmd during WAIT_TX
        rx_q.push_back(8'hA5);
        tx_log_a.delete(); got_q.delete();
        s_trmt = n_trmt_a; s_clr = n_clr_a; s_done = n_done_a;
        start_a(24'h082ABB, 16'd1);
        check("accept busy", busy_a, 1);
        n = 0;
        while (tx_log_a.size() == 0 && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        cmd_a = 24'hFFFFFF;
        send_a = 1'b1;
        @(negedge clk);
        send_a = 1'b0;
        wait_done_a("eep_wr");
        check("eep_wr trmt count", n_trmt_a - s_trmt, 3);
        check("eep_wr tx bytes", {tx_log_a[0], tx_log_a[1], tx_log_a[2]}, 24'h082ABB);
        check("eep_wr resp count", got_q.size(), 1);
        check("eep_wr resp byte", got_q[0], 8'hA5);
        check("eep_wr ack_ok", ack_ok_a, 1);
        check("eep_wr done pulses", n_done_a - s_done, 1);
        check("eep_wr clr pulses", n_clr_a - s_clr, 1);
        check("eep_wr timeout/busy", {timeout_a, busy_a}, 0);

        // NAK on EEP read
        rx_q.push_back(8'hBB);
        got_q.delete();
        start_a(24'h092AFF, 16'd1);
        wait_done_a("nak");
        check("nak resp byte", got_q.size() == 1 ? got_q[0] : 8'h00, 8'hBB);
        check("nak ack_ok", ack_ok_a, 0);

        // Trigger read
        rx_q.push_back(8'h38);
        got_q.delete();
        start_a(24'h0700E0, 16'd1);
        wait_done_a("trig_rd");
        check("trig_rd resp byte", got_q.size() == 1 ? got_q[0] : 8'h00, 8'h38);

        // 510-byte dump with random backpressure
        for (int i = 0; i < 510; i++) rx_q.push_back(i == 0 ? 8'hA5 : (8'(i) ^ 8'h3C));
        got_q.delete();
        ack_mode = 1;
        s_clr = n_clr_a; s_done = n_done_a; s_uns = n_unstable;
        start_a(24'h0100FF, 16'd510);
        wait_done_a("dump");
        ack_mode = 0;
        check("dump resp count", got_q.size(), 510);
        errs = 0;
        for (int i = 0; i < got_q.size(); i++) begin
            e = (i == 0) ? 8'hA5 : (8'(i) ^ 8'h3C);
            if (got_q[i] !== e) errs++;
        end
        check("dump order", errs, 0);
        check("dump clr pulses", n_clr_a - s_clr, 510);
        check("dump stall stability", n_unstable - s_uns, 0);
        check("dump done pulses", n_done_a - s_done, 1);
        check("dump ack_ok", ack_ok_a, 1);
        check("dump timeout", timeout_a, 0);

        // Response never arrives
        s_done = n_done_a;
        start_a(24'h0700E0, 16'd1);
        wait_done_a("timeout");
        check("timeout flag", timeout_a, 1);
        check("timeout latency", done_cyc - txd_cyc, 65);
        check("timeout busy/ack", {busy_a, ack_ok_a}, 0);
        check("timeout done pulses", n_done_a - s_done, 1);
        rx_q.push_back(8'h38);
        got_q.delete();
        start_a(24'h0700E0, 16'd1);
        check("timeout cleared on accept", timeout_a, 0);
        wait_done_a("after_timeout");
        check("after_timeout resp", got_q.size() == 1 ? got_q[0] : 8'h00, 8'h38);

        // Abort while waiting for the response
        s_clr = n_clr_a;
        start_a(24'h092AFF, 16'd1);
        n = 0;
        while (!(tx_log_a.size() >= 1 && n_trmt_a - s_trmt >= 0 && tx_done_a && txw_a == 0
                 && busy_a && trmt_a == 1'b0 && n_trmt_a % 3 == 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        @(negedge clk);
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        check("abort done next cycle", done_a, 1);
        @(negedge clk);
        check("abort single done", done_a, 0);
        check("abort no clr", n_clr_a - s_clr, 0);
        check("abort timeout unchanged", {timeout_a, busy_a}, 0);

        // Asynchronous reset while stalled in FWD
        rx_q.push_back(8'hA5);
        ack_mode = 2;
        start_a(24'h0700E0, 16'd2);
        n = 0;
        while (resp_vld_a !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        check("fwd reached", resp_vld_a, 1);
        check("fwd ack captured", ack_ok_a, 1);
        #2 rst = 1'b1;
        #1;
        check("async reset outputs",
              {busy_a, trmt_a, clr_a, resp_vld_a, done_a, ack_ok_a, timeout_a, tx_data_a, resp_data_a}, 0);
        @(negedge clk);
        rst = 1'b0;
        ack_mode = 0;
        @(negedge clk);

        // Four-byte command with no response phase
        tx_log_b.delete();
        cmd_b = 32'hDEADBEEF;
        send_b = 1'b1;
        @(negedge clk);
        send_b = 1'b0;
        n = 0;
        while (done_b !== 1'b1 && n < 500) begin @(negedge clk); n++; end
        check("cmd4 done seen", done_b, 1);
        @(negedge clk);
        @(negedge clk);
        check("cmd4 trmt count", n_trmt_b, 4);
        check("cmd4 tx bytes", tx_log_b.size() == 4 ?
              {tx_log_b[0], tx_log_b[1], tx_log_b[2], tx_log_b[3]} : 32'h0, 32'hDEADBEEF);
        check("cmd4 no response phase", {n_clr_b[7:0], n_vld_b[7:0]}, 0);
        check("cmd4 done pulses", n_done_b, 1);
        check("cmd4 timeout/busy", {timeout_b, busy_b}, 0);

        check("tx_data stable before trmt", n_txjit, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_cmd_host.md
Name: uart_cmd_host

Overview:
Synthesizable host-side command engine for the DSO digital core. It serializes a parametrised N-byte command, MSB byte first, into a UART transmitter using the trmt/tx_done handshake. It then collects a programmable number of response bytes from a UART receiver using the cmd_rdy/clr_cmd_rdy handshake and forwards them downstream with backpressure. It also performs ACK checking and per-byte timeout. It sits between a host controller (or bench) and a UART_comm instance cross-connected to DSO_dig.

Parameters:
CMD_BYTES, 3, bytes per command (>=1)
RESP_W, 16, width of response-count field (max 2^RESP_W-1 bytes, e.g. 510-byte dumps)
TO_W, 20, timeout counter width; timeout after 2^TO_W-1 idle cycles per awaited byte
ACK_BYTE, 8'hA5, positive acknowledge value

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
cmd  in  8*CMD_BYTES  command word, byte [8*CMD_BYTES-1 -: 8] sent first
resp_cnt  in  RESP_W  number of response bytes expected; 0 = none
send_cmd  in  1  start pulse; sampled only in IDLE
abort  in  1  synchronous abort, any state
busy  out  1  high from accept until done
tx_data  out  8  byte to UART transmitter
trmt  out  1  one-cycle transmit strobe
tx_done  in  1  transmitter done (level; rising edge used)
rx_data  in  8  received byte
rx_rdy  in  1  receiver byte-ready (level)
clr_rx_rdy  out  1  one-cycle clear to receiver
resp_data  out  8  forwarded response byte
resp_vld  out  1  resp_data valid
resp_ack  in  1  downstream accepts byte when resp_vld&resp_ack
done  out  1  one-cycle completion pulse
ack_ok  out  1  first response byte == ACK_BYTE (valid with done, held until next accept)
timeout  out  1  sticky error: wait expired; cleared on next accept

Behaviour:
- Reset: state IDLE; busy, trmt, clr_rx_rdy, resp_vld, done, ack_ok, timeout = 0; tx_data = 0; counters = 0.
- States: IDLE, LOAD, TRMT, WAIT_TX, WAIT_RX, FWD, CLR, DONE.
- IDLE:
  - send_cmd=1: latch cmd into shift reg, latch resp_cnt, byte_idx=0, clear ack_ok/timeout, busy=1 next cycle -> LOAD.
  - send_cmd while busy is ignored; no queuing.
- LOAD: tx_data = top byte of shift reg -> TRMT. tx_data is stable at least one cycle before trmt and held through WAIT_TX.
- TRMT: trmt=1 for exactly one cycle -> WAIT_TX.
- WAIT_TX: wait for tx_done rising edge (registered previous value). Then shift reg left 8 and byte_idx++.
  - byte_idx==CMD_BYTES-1 -> (resp_cnt==0 ? DONE : WAIT_RX).
  - otherwise -> LOAD.
  - Minimum gap between successive trmt pulses is 3 cycles plus the UART frame time.
- WAIT_RX: rx_rdy=1 -> FWD with resp_data=rx_data registered. If this is the first response byte, ack_ok = (rx_data==ACK_BYTE).
- FWD: resp_vld=1 until resp_ack. resp_data must not change while resp_vld=1 and resp_ack=0. On handshake -> CLR.
- CLR: clr_rx_rdy=1 one cycle; remaining count-1. Count reaches 0 -> DONE, else WAIT_RX.
- DONE: done=1 one cycle, busy=0 -> IDLE.
- Timeout:
  - Counter is reset on entry to WAIT_TX/WAIT_RX and increments while waiting.
  - Reaching all-ones sets timeout=1 -> DONE; ack_ok=0 unless the ACK was already captured.
  - FWD is not timed: downstream backpressure is legal indefinitely.
- abort=1: trmt/clr_rx_rdy/resp_vld drop next cycle -> DONE (done pulse issued); timeout unchanged. Simultaneous abort and send_cmd in IDLE: abort wins, command not accepted.
- rx_rdy in IDLE or WAIT_TX is ignored; unsolicited bytes are not cleared.
- Reset mid-operation: immediate return to reset values, with no trmt/clr pulse emitted.
- Counters: remaining count is RESP_W bits, decremented only in CLR, never wraps. byte_idx is $clog2(CMD_BYTES+1) bits.

Decomposition:
- Package dso_host_pkg: state enum, ACK_BYTE default, the DSO command opcodes (DUMP_CH 8'h01 … EEP_RD 8'h09).
- Natural sub-module: host_wait_timer (load/enable/expire counter, parameter TO_W), instantiated once.

Test Plan:
- EEP write: cmd=24'h082ABB, resp_cnt=1, UART model returns A5 -> tx_data sequence 08,2A,BB with exactly 3 trmt pulses; resp_data=A5; ack_ok=1; done one pulse; timeout=0.
- NAK and read: cmd=24'h092AFF, resp_cnt=1, returns BB -> resp_data=BB, ack_ok=0, done. cmd=24'h0700E0, rx 38 -> resp_data=38.
- Dump with backpressure: cmd=24'h0100FF, resp_cnt=510, resp_ack toggled randomly 50% -> 510 resp_vld handshakes in order, 510 clr_rx_rdy pulses, resp_data stable while stalled, done after last.
- Timeout: TO_W=6, resp_cnt=1, receiver never asserts rx_rdy -> timeout=1 after 63 wait cycles, done pulse, busy=0; next send_cmd clears timeout.
- Abort/ignore: send_cmd during WAIT_TX is ignored (trmt count unchanged); abort in WAIT_RX -> done next cycle, no clr_rx_rdy; async rst mid-FWD -> all outputs 0 same cycle.
- Parametric: CMD_BYTES=4, cmd=32'hDEADBEEF, resp_cnt=0 -> bytes DE,AD,BE,EF, done with no response phase.
